// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: transmit end of the BNN nibble weight-load link.
// Buffers one weight byte per neuron and streams them low nibble first,
// neuron 0 upward, while mirroring the core's neuron load pointer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; host may write the buffer
// S_STREAM | presenting nibbles; wt_load follows ~hold
// S_DONE   | one-cycle completion pulse, then back to idle
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int PTR_W       = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic             start_i,
  input  logic             hold_i,
  output logic [3:0]       wt_nibble_o,
  output logic             wt_load_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             rejected_o,
  output logic [PTR_W-1:0] rx_ptr_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // The core's power-on weights; the buffer comes out of reset matching them.
  function automatic logic [7:0] default_w(input int i);
    case (i)
      0:       default_w = 8'hA0;
      1:       default_w = 8'h41;
      2:       default_w = 8'h7A;
      3:       default_w = 8'h18;
      4:       default_w = 8'hED;
      5:       default_w = 8'hB7;
      6:       default_w = 8'h67;
      7:       default_w = 8'h3A;
      8:       default_w = 8'hF9;
      9:       default_w = 8'h62;
      10:      default_w = 8'hF7;
      11:      default_w = 8'h0F;
      default: default_w = 8'h00;
    endcase
  endfunction

  logic [7:0]       buf_q [NUM_NEURONS];
  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [PTR_W-1:0] rx_ptr_q, rx_ptr_d;
  logic             rejected_q, rejected_d;
  logic [7:0]       cur_byte;
  logic             streaming;

  assign streaming = (state_q == S_STREAM);
  assign cur_byte  = buf_q[idx_q];

  // Host writes land only outside a stream and only on valid entries.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) buf_q[i] <= default_w(i);
    end else if (wr_en_i && !streaming && (32'(wr_addr_i) < NUM_NEURONS)) begin
      buf_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Next-state logic: one nibble per unheld cycle, pointer bumps on the high nibble.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    rx_ptr_d   = rx_ptr_q;
    rejected_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (rx_ptr_q == '0) begin
            state_d = S_STREAM;
            idx_d   = 4'd0;
            phase_d = 1'b0;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (!hold_i) begin
          phase_d = ~phase_q;
          if (phase_q) begin
            idx_d    = idx_q + 4'd1;
            rx_ptr_d = rx_ptr_q + PTR_W'(1);
            if (idx_q == 4'(NUM_NEURONS - 1)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; reset returns both ends of the link to pointer 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      phase_q    <= 1'b0;
      rx_ptr_q   <= '0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      rx_ptr_q   <= rx_ptr_d;
      rejected_q <= rejected_d;
    end
  end

  // Outputs are decoded from registered state so reset drops wt_load at once.
  always_comb begin
    wt_nibble_o = 4'd0;
    if (streaming) wt_nibble_o = phase_q ? cur_byte[7:4] : cur_byte[3:0];
  end

  assign wt_load_o  = streaming & ~hold_i;
  assign busy_o     = streaming;
  assign done_o     = (state_q == S_DONE);
  assign rejected_o = rejected_q;
  assign rx_ptr_o   = rx_ptr_q;

endmodule

// File: doc/bnn_weight_streamer.md
# bnn_weight_streamer

- Transmit end of the BNN nibble weight-load interface.
- Holds a 12-entry × 8-bit weight buffer that the host fills through a byte write port.
- On `start`, streams the whole buffer as low-nibble/high-nibble pairs with a load strobe, in the order the BNN core consumes them: neuron 0 first, then 1, 2, … up to 11.
- Its `wt_nibble`/`wt_load` outputs drive the core's `uio_in[7:4]` and `uio_in[3]`. It keeps a mirror of the core's neuron pointer so it never overruns the core's weight array.

## Interface
Parameters:
- `NUM_NEURONS`, 12, number of weight bytes buffered and streamed per load.
- `PTR_W`, 5, width of the neuron-pointer mirror; matches the core's load pointer.

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  host buffer write strobe.
- `wr_addr`  in  4  buffer entry index.
- `wr_data`  in  8  weight byte; bit i is the weight for input i.
- `start`  in  1  single-cycle request to stream the buffer.
- `hold`  in  1  pause; drive it with the inverse of the core's `ena`.
- `wt_nibble`  out  4  nibble presented to the core.
- `wt_load`  out  1  load strobe to the core.
- `busy`  out  1  high while a stream is in progress.
- `done`  out  1  one-cycle pulse when a stream completes.
- `rejected`  out  1  one-cycle pulse when `start` is refused.
- `rx_ptr`  out  PTR_W  mirror of the core's neuron pointer.

## Operation
Reset values:
- Buffer entries 0..11 = 0xA0, 0x41, 0x7A, 0x18, 0xED, 0xB7, 0x67, 0x3A, 0xF9, 0x62, 0xF7, 0x0F (the core's power-on weights).
- State = IDLE; `rx_ptr` = 0; `idx` = 0; `phase` = 0; `wt_nibble` = 0.
- `wt_load`, `busy`, `done`, `rejected` = 0.

Buffer write:
- On a clock edge with `wr_en` = 1, `busy` = 0 and `wr_addr` < NUM_NEURONS, entry[`wr_addr`] ← `wr_data`.
- Writes while busy are dropped. Writes with `wr_addr` ≥ NUM_NEURONS are dropped.

State machine:
- IDLE:
  - `start` = 1 and `rx_ptr` = 0 → go to STREAM with `idx` = 0, `phase` = 0.
  - `start` = 1 and `rx_ptr` ≠ 0 → `rejected` pulses the next cycle; stay in IDLE.
- STREAM:
  - `busy` = 1.
  - `wt_nibble` = entry[`idx`][3:0] when `phase` = 0, entry[`idx`][7:4] when `phase` = 1. This output is combinational from the registered `idx`/`phase`.
  - `wt_load` = ~`hold` (combinational).
  - On each edge with `hold` = 0, `phase` toggles.
  - On the phase-1 edge: `idx` and `rx_ptr` increment.
  - When `idx` = NUM_NEURONS−1 and `phase` = 1 at an unheld edge → go to DONE.
- DONE: `done` = 1 for one cycle, `busy` = 0, then go to IDLE.

`rx_ptr` rule:
- It only increments; it is cleared only by `reset`. It mirrors the core pointer, which is likewise cleared only by the core reset.
- Only one full load per reset is accepted. A second `start` without reset is rejected.

Other rules:
- `start` while in STREAM or DONE is ignored; no `rejected` pulse.
- `hold` in IDLE has no effect.
- Reset mid-stream: everything returns to reset values immediately and `wt_load` drops asynchronously.
  - Because the core shares the reset, both ends restart from pointer 0 and the nibble phase.
  - No partial pair is ever left in the core.

## Timing
- `start` is sampled at edge T; `busy` is high from T+1.
- The first nibble (entry 0 bits [3:0]) with `wt_load` = 1 is valid during cycle T+1 and is captured by the core at edge T+2.
- With no `hold`, there are 24 consecutive `wt_load` cycles, T+1..T+24. `done` is high in cycle T+25, and `busy` is low from T+25.
- Each `hold` cycle adds exactly one cycle of latency. During that cycle `wt_load` = 0, and `wt_nibble` keeps its current value and phase.
- `hold` between the low and high nibble of one neuron is legal. The core keeps its own half-pair state.
- `rx_ptr` updates at the same edge at which the core commits the byte.
- Throughput: 2 cycles per neuron.

## Test plan
- Reset, then `start`:
  - `wt_nibble` sequence is 0, A, 1, 4, A, 7, 8, 1, …, F, 0.
  - `wt_load` is high for 24 cycles.
  - `done` is high at T+25.
  - `rx_ptr` ends at 12.
- Write entry 0 = 0x5C, then `start`, driving a core model:
  - Core weights[0] = 0x5C.
  - Core `uo_out[3:0]` = 0x5.
  - All other core weights equal the defaults.
- Assert `hold` on cycles T+2 and T+5:
  - `wt_load` is low on exactly those cycles.
  - Nibbles are not skipped or repeated.
  - `done` is high at T+27.
- Second `start` after completion: `rejected` pulses once, `wt_load` stays 0, `rx_ptr` stays 12.
- `wr_en` with address 3 while busy, and with address 13 while idle: buffer unchanged; a re-stream after reset shows 0x18 for entry 3.
- Assert `reset` at T+9 (mid neuron 4):
  - Outputs return to reset values immediately.
  - `rx_ptr` = 0.
  - A new `start` streams all 24 nibbles from entry 0.
